ifft_unit: RTL and testbench

- Frame-based spectral processor between the ADC capture path and the DAC.
- Captures N_POINTS 10-bit ADC samples and computes a sequential forward DFT.
- Scales every bin by one complex coefficient (ram_add_real + j·ram_add_img), then runs an inverse DFT.
- Replays the resulting real frame cyclically to da_data at the sample rate.

---
 rtl/ifft_pkg.sv | 77 +++++++
 rtl/ifft_twiddle_rom.sv | 15 +
 rtl/ifft_unit.sv | 154 +++++++++++++++
 tb/tb_ifft_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared constants, FSM state type and the Q1.14 twiddle generator for the ifft_unit spectral processor.
package ifft_pkg;

  localparam int N_POINTS  = 64;
  localparam int LOG2N     = 6;
  localparam int DATA_W    = 10;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 0;
  localparam int TW_W      = 16;
  localparam int TW_FRAC   = 14;
  localparam int MID_SCALE = 512;

  // Datapath widths sized so the worst-case sums cannot overflow.
  localparam int X_W    = DATA_W + 1;
  localparam int FACC_W = X_W + TW_W + LOG2N + 1;
  localparam int FX_W   = FACC_W - TW_FRAC;
  localparam int Y_W    = FX_W + COEF_W + 1;
  localparam int IACC_W = Y_W + TW_W + LOG2N + 1;
  localparam int CNT_W  = LOG2N + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FWD     = 3'd2,
    INV     = 3'd3,
    SWAP    = 3'd4
  } state_t;

  // Quarter-wave table: round(16384 * sin(2*pi*i/64)), i = 0..16.
  function automatic logic signed [TW_W-1:0] qsin(input logic [4:0] i);
    case (i)
      5'd0:    return 16'sd0;
      5'd1:    return 16'sd1606;
      5'd2:    return 16'sd3196;
      5'd3:    return 16'sd4756;
      5'd4:    return 16'sd6270;
      5'd5:    return 16'sd7723;
      5'd6:    return 16'sd9102;
      5'd7:    return 16'sd10394;
      5'd8:    return 16'sd11585;
      5'd9:    return 16'sd12665;
      5'd10:   return 16'sd13623;
      5'd11:   return 16'sd14449;
      5'd12:   return 16'sd15137;
      5'd13:   return 16'sd15679;
      5'd14:   return 16'sd16069;
      5'd15:   return 16'sd16305;
      5'd16:   return 16'sd16384;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] sin_q14(input logic [LOG2N-1:0] idx);
    logic [4:0] r;
    r = {1'b0, idx[3:0]};
    case (idx[5:4])
      2'd0:    return qsin(r);
      2'd1:    return qsin(5'd16 - r);
      2'd2:    return -qsin(r);
      default: return -qsin(5'd16 - r);
    endcase
  endfunction

  // Returns {cos, sin} of 2*pi*idx/N; cos is sin advanced by a quarter turn.
  function automatic logic [2*TW_W-1:0] twiddle(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] c_idx;
    c_idx = idx + LOG2N'(N_POINTS / 4);
    return {sin_q14(c_idx), sin_q14(idx)};
  endfunction

  function automatic logic [DATA_W-1:0] dac_clamp(input logic signed [IACC_W-1:0] v);
    if (v < 0) return '0;
    if (v > IACC_W'(2 ** DATA_W - 1)) return '1;
    return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/ifft_twiddle_rom.sv
// Synchronous twiddle ROM: {cos, sin} of address (n*k mod N), one cycle after the address.
module ifft_twiddle_rom
  import ifft_pkg::*;
(
  input  logic                   calcu_clk,
  input  logic [LOG2N-1:0]       addr,
  output logic signed [TW_W-1:0] cos_q,
  output logic signed [TW_W-1:0] sin_q
);

  always_ff @(posedge calcu_clk) begin
    {cos_q, sin_q} <= twiddle(addr);
  end

endmodule

// File: rtl/ifft_unit.sv
// Frame processor: capture N ADC samples, forward DFT, per-bin complex gain, inverse DFT, cyclic DAC replay.
module ifft_unit
  import ifft_pkg::*;
(
  input  logic              calcu_clk,
  input  logic              sys_rst,
  input  logic              sample_en,
  input  logic [8:0]        key,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [COEF_W-1:0] ram_add_real,
  input  logic [COEF_W-1:0] ram_add_img,
  input  logic              ifft_start,
  output logic              fft_m_data_tvalid,
  output logic [DATA_W-1:0] da_data,
  output logic [2:0]        fsm_state
);

  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N_POINTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_POINTS + 1);
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N_POINTS - 1);

  state_t state, state_next;

  // cnt walks the inner sum index plus two pipeline cycles; idx is the outer bin/sample index.
  logic [CNT_W-1:0] cnt;
  logic [LOG2N-1:0] idx, wr_ptr, rd_ptr;
  logic             frame_valid, active_bank;

  logic [DATA_W-1:0]     in_buf   [N_POINTS];
  logic signed [Y_W-1:0] yr_mem   [N_POINTS];
  logic signed [Y_W-1:0] yi_mem   [N_POINTS];
  logic [DATA_W-1:0]     out_bank [2][N_POINTS];

  logic [LOG2N-1:0]        rd_idx, tw_addr;
  logic signed [TW_W-1:0]  tw_c, tw_s;
  logic [DATA_W-1:0]       in_q;
  logic signed [Y_W-1:0]   yr_q, yi_q;
  logic                    acc_en, acc_first, bin_end;
  logic signed [X_W-1:0]   x_s;
  logic signed [FACC_W-1:0] fp_c, fp_s, facc_r, facc_i;
  logic signed [FX_W-1:0]  fx_r, fx_i;
  logic signed [Y_W-1:0]   c_r, c_i, y_r, y_i;
  logic signed [IACC_W-1:0] ip, iacc, y_out;
  logic                    unused_key;

  assign unused_key = ^key[8:1];

  ifft_twiddle_rom u_rom (
    .calcu_clk (calcu_clk),
    .addr      (tw_addr),
    .cos_q     (tw_c),
    .sin_q     (tw_s)
  );

  // Operands are issued at cnt = 0..N-1 and arrive (ROM and buffers) one cycle later.
  assign rd_idx    = cnt[LOG2N-1:0];
  assign tw_addr   = rd_idx * idx;
  assign acc_en    = (cnt != '0) && (cnt <= CNT_N);
  assign acc_first = (cnt == CNT_W'(1));
  assign bin_end   = (cnt == CNT_LAST);

  assign x_s  = $signed({1'b0, in_q}) - X_W'(MID_SCALE);
  assign fp_c = FACC_W'(x_s) * FACC_W'(tw_c);
  assign fp_s = FACC_W'(x_s) * FACC_W'(tw_s);

  assign fx_r = FX_W'(facc_r >>> TW_FRAC);
  assign fx_i = FX_W'(facc_i >>> TW_FRAC);
  assign c_r  = Y_W'($signed(ram_add_real));
  assign c_i  = Y_W'($signed(ram_add_img));
  assign y_r  = (Y_W'(fx_r) * c_r - Y_W'(fx_i) * c_i) >>> COEF_FRAC;
  assign y_i  = (Y_W'(fx_r) * c_i + Y_W'(fx_i) * c_r) >>> COEF_FRAC;

  assign ip    = IACC_W'(yr_q) * IACC_W'(tw_c) - IACC_W'(yi_q) * IACC_W'(tw_s);
  assign y_out = (iacc >>> (TW_FRAC + LOG2N)) + IACC_W'(MID_SCALE);

  // fft_m_data_tvalid is a level, not a handshake: high while the active bank holds a finished frame.
  assign fft_m_data_tvalid = frame_valid;
  assign fsm_state         = state;

  always_ff @(posedge calcu_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ifft_start) state_next = CAPTURE;
      CAPTURE: if (sample_en && wr_ptr == IDX_LAST) state_next = FWD;
      FWD:     if (bin_end && idx == IDX_LAST) state_next = INV;
      INV:     if (bin_end && idx == IDX_LAST) state_next = SWAP;
      SWAP:    state_next = ifft_start ? CAPTURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge calcu_clk) begin
    if (sys_rst) begin
      cnt         <= '0;
      idx         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_valid <= 1'b0;
      active_bank <= 1'b0;
      da_data     <= DATA_W'(MID_SCALE);
    end else begin
      if (state == FWD || state == INV) begin
        if (bin_end) begin
          cnt <= '0;
          idx <= idx + LOG2N'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
        idx <= '0;
      end
      if (state == CAPTURE && sample_en) wr_ptr <= wr_ptr + LOG2N'(1);
      if (sample_en) begin
        if (key[0])           da_data <= ad_data;
        else if (frame_valid) da_data <= out_bank[active_bank][rd_ptr];
        if (frame_valid) rd_ptr <= rd_ptr + LOG2N'(1);
      end
      if (state == SWAP) begin
        active_bank <= ~active_bank;
        frame_valid <= 1'b1;
        rd_ptr      <= '0;
      end
    end
  end

  // Buffers and accumulators need no reset: every frame overwrites them before use.
  always_ff @(posedge calcu_clk) begin
    if (state == CAPTURE && sample_en) in_buf[wr_ptr] <= ad_data;
    in_q <= in_buf[rd_idx];
    yr_q <= yr_mem[rd_idx];
    yi_q <= yi_mem[rd_idx];
    if (state == FWD) begin
      if (acc_en) begin
        facc_r <= acc_first ? fp_c : facc_r + fp_c;
        facc_i <= acc_first ? -fp_s : facc_i - fp_s;
      end
      if (bin_end) begin
        yr_mem[idx] <= y_r;
        yi_mem[idx] <= y_i;
      end
    end
    if (state == INV) begin
      if (acc_en) iacc <= acc_first ? ip : iacc + ip;
      if (bin_end) out_bank[~active_bank][idx] <= dac_clamp(y_out);
    end
  end

endmodule

// File: tb/tb_ifft_unit.sv
// Directed bench for ifft_unit: reset, identity, sine, zero/negative gain, saturation, bypass, restart.
module tb_ifft_unit;
  import ifft_pkg::*;

  localparam int SP        = 4;     // clock cycles per sample strobe
  localparam int PROC_WAIT = 8460;  // just above the capture-to-swap latency bound

  logic              calcu_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              sample_en = 1'b0;
  logic [8:0]        key = '0;
  logic [DATA_W-1:0] ad_data = 10'd512;
  logic [COEF_W-1:0] ram_add_real = 16'd1;
  logic [COEF_W-1:0] ram_add_img = 16'd0;
  logic              ifft_start = 1'b0;
  logic              fft_m_data_tvalid;
  logic [DATA_W-1:0] da_data;
  logic [2:0]        fsm_state;

  int checks = 0;
  int errors = 0;
  int sine_tab [16] = '{512, 589, 653, 697, 712, 697, 653, 589,
                        512, 435, 371, 327, 312, 327, 371, 435};
  int frame_in [N_POINTS];
  int exp_val  [N_POINTS];
  int exp_tol  [N_POINTS];

  ifft_unit dut (
    .calcu_clk         (calcu_clk),
    .sys_rst           (sys_rst),
    .sample_en         (sample_en),
    .key               (key),
    .ad_data           (ad_data),
    .ram_add_real      (ram_add_real),
    .ram_add_img       (ram_add_img),
    .ifft_start        (ifft_start),
    .fft_m_data_tvalid (fft_m_data_tvalid),
    .da_data           (da_data),
    .fsm_state         (fsm_state)
  );

  always #10 calcu_clk = ~calcu_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge calcu_clk);
  endtask

  task automatic strobe(input int v);
    @(negedge calcu_clk);
    ad_data   = 10'(v);
    sample_en = 1'b1;
    @(negedge calcu_clk);
    sample_en = 1'b0;
    repeat (SP - 2) @(negedge calcu_clk);
  endtask

  task automatic capture_frame(input bit keep_start);
    @(negedge calcu_clk);
    ifft_start = 1'b1;
    for (int i = 0; i < N_POINTS; i++) begin
      strobe(frame_in[i]);
      if (i == 0 && !keep_start) ifft_start = 1'b0;
    end
  endtask

  task automatic play_check(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      strobe(512);
      check_near($sformatf("%s[%0d]", tag, i), int'(da_data), exp_val[i], exp_tol[i]);
    end
  endtask

  function automatic int clamp_dac(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  initial begin
    // Reset held for three cycles.
    cycles(3);
    sys_rst = 1'b0;
    cycles(1);
    check_eq("rst_da", int'(da_data), 512);
    check_eq("rst_tvalid", int'(fft_m_data_tvalid), 0);
    check_eq("rst_state", int'(fsm_state), int'(IDLE));

    // Identity gain, constant 700; output must stay at mid-scale until the first swap.
    ram_add_real = 16'd1;
    ram_add_img  = 16'd0;
    for (int i = 0; i < N_POINTS; i++) frame_in[i] = 700;
    @(negedge calcu_clk);
    ifft_start = 1'b1;
    for (int i = 0; i < N_POINTS; i++) begin
      strobe(frame_in[i]);
      if (i == 0) ifft_start = 1'b0;
      if (i == 0 || i == 40) begin
        check_eq($sformatf("pre_swap_da[%0d]", i), int'(da_data), 512);
        check_eq($sformatf("pre_swap_tvalid[%0d]", i), int'(fft_m_data_tvalid), 0);
      end
    end
    cycles(PROC_WAIT);
    check_eq("id_state_idle", int'(fsm_state), int'(IDLE));
    check_eq("id_tvalid", int'(fft_m_data_tvalid), 1);
    for (int i = 0; i < N_POINTS; i++) begin exp_val[i] = 700; exp_tol[i] = 2; end
    play_check("identity", N_POINTS);

    // 16-sample sine with unity gain reproduces the captured frame from index 0.
    for (int i = 0; i < N_POINTS; i++) frame_in[i] = sine_tab[i % 16];
    capture_frame(1'b0);
    cycles(PROC_WAIT);
    for (int i = 0; i < N_POINTS; i++) begin exp_val[i] = sine_tab[i % 16]; exp_tol[i] = 2; end
    play_check("sine", N_POINTS);

    // Zero gain gives exact mid-scale.
    ram_add_real = 16'd0;
    for (int i = 0; i < N_POINTS; i++) frame_in[i] = 700;
    capture_frame(1'b0);
    cycles(PROC_WAIT);
    for (int i = 0; i < N_POINTS; i++) begin exp_val[i] = 512; exp_tol[i] = 0; end
    play_check("gain_zero", 16);

    // Gain of -1 mirrors 700 about mid-scale.
    ram_add_real = 16'hFFFF;
    capture_frame(1'b0);
    cycles(PROC_WAIT);
    for (int i = 0; i < N_POINTS; i++) begin exp_val[i] = 324; exp_tol[i] = 2; end
    play_check("gain_neg", 16);

    // Gain of 4 on the sine drives the peaks hard into both rails.
    ram_add_real = 16'd4;
    for (int i = 0; i < N_POINTS; i++) frame_in[i] = sine_tab[i % 16];
    capture_frame(1'b0);
    cycles(PROC_WAIT);
    for (int i = 0; i < N_POINTS; i++) begin
      int v;
      v = 512 + 4 * (sine_tab[i % 16] - 512);
      exp_val[i] = clamp_dac(v);
      exp_tol[i] = (v < 0 || v > 1023) ? 0 : 8;
    end
    play_check("saturate", 32);

    // Bypass follows ad_data on the same strobe and leaves tvalid alone.
    key = 9'h1FF;
    strobe(300);
    check_eq("bypass_300", int'(da_data), 300);
    strobe(1023);
    check_eq("bypass_1023", int'(da_data), 1023);
    strobe(0);
    check_eq("bypass_0", int'(da_data), 0);
    check_eq("bypass_tvalid", int'(fft_m_data_tvalid), 1);
    key = 9'h000;

    // ifft_start dropped during FWD: frame finishes, swaps once, FSM parks in IDLE.
    ram_add_real = 16'd1;
    for (int i = 0; i < N_POINTS; i++) frame_in[i] = 600;
    capture_frame(1'b1);
    cycles(10);
    check_eq("restart_in_fwd", int'(fsm_state), int'(FWD));
    ifft_start = 1'b0;
    for (int i = 0; i < 400; i++) strobe(100);
    cycles(PROC_WAIT - 1600);
    check_eq("restart_idle", int'(fsm_state), int'(IDLE));
    check_eq("restart_tvalid", int'(fft_m_data_tvalid), 1);
    for (int i = 0; i < N_POINTS; i++) begin exp_val[i] = 600; exp_tol[i] = 2; end
    play_check("restart", 16);
    cycles(50);
    check_eq("restart_still_idle", int'(fsm_state), int'(IDLE));

    // Reset in the middle of a capture invalidates playback.
    @(negedge calcu_clk);
    ifft_start = 1'b1;
    for (int i = 0; i < 10; i++) strobe(800);
    ifft_start = 1'b0;
    check_eq("midrst_capture", int'(fsm_state), int'(CAPTURE));
    @(negedge calcu_clk);
    sys_rst = 1'b1;
    @(negedge calcu_clk);
    sys_rst = 1'b0;
    check_eq("midrst_da", int'(da_data), 512);
    check_eq("midrst_tvalid", int'(fft_m_data_tvalid), 0);
    check_eq("midrst_state", int'(fsm_state), int'(IDLE));
    strobe(900);
    check_eq("midrst_hold_da", int'(da_data), 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
